decode_queue: RTL and testbench

// - FETCH_W-wide RV32IM decode stage with a DEPTH-entry queue of decoded micro-ops between fetch and rename/dispatch.
// - Each cycle it decodes up to FETCH_W instructions and enqueues valid lanes in lane order (gaps compacted).
// - Dispatch pops one decoded op per cycle through a valid/ready handshake.
// - Adds sign-extended immediate generation, synthesizable illegal detection, flush and back-pressure.

---
 rtl/decode_queue.sv | 210 +++++++++++++++++++++
 tb/tb_decode_queue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue
// RV32IM decode stage for FETCH_W instructions per cycle, followed by a
// DEPTH-entry queue of decoded micro-ops feeding rename/dispatch.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous reset, active low
//   flush          drop every queued op (mispredict/trap)
//   in_valid       per-lane instruction valid
//   in_instr       lane i instruction at [32*i +: 32]
//   in_pc          lane i PC at [XLEN*i +: XLEN]
//   in_ready       queue has room for a full fetch group
//   out_valid      head entry valid
//   out_ready      dispatch consumes the head entry
//   out_pc         head PC
//   out_instr      head raw instruction
//   out_alu_opcode {branch, f7b5-qualified, funct3}
//   out_alu_m_inst M-extension op
//   out_load_store {load, store}
//   out_rd_inst    op writes rd
//   out_cont_tra   {jalr, jal, branch}
//   out_imm        sign-extended immediate
//   out_illegal    illegal/unimplemented encoding
//   count          occupied entries
module decode_queue #(
    parameter int XLEN    = 32,
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [FETCH_W-1:0]        in_valid,
    input  logic [FETCH_W*32-1:0]     in_instr,
    input  logic [FETCH_W*XLEN-1:0]   in_pc,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_instr,
    output logic [4:0]                out_alu_opcode,
    output logic                      out_alu_m_inst,
    output logic [1:0]                out_load_store,
    output logic                      out_rd_inst,
    output logic [2:0]                out_cont_tra,
    output logic [31:0]               out_imm,
    output logic                      out_illegal,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      alu_opcode;
        logic            alu_m_inst;
        logic [1:0]      load_store;
        logic            rd_inst;
        logic [2:0]      cont_tra;
        logic [31:0]     imm;
        logic            illegal;
    } uop_t;

    function automatic uop_t decode_lane(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        uop_t       u;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
        logic       is_load, is_store, is_op_imm, is_op, is_misc, is_system;
        logic       known, illegal, f7b5;
        logic [31:0] imm;

        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];

        is_lui    = (opc == OPC_LUI);
        is_auipc  = (opc == OPC_AUIPC);
        is_jal    = (opc == OPC_JAL);
        is_jalr   = (opc == OPC_JALR);
        is_branch = (opc == OPC_BRANCH);
        is_load   = (opc == OPC_LOAD);
        is_store  = (opc == OPC_STORE);
        is_op_imm = (opc == OPC_OP_IMM);
        is_op     = (opc == OPC_OP);
        is_misc   = (opc == OPC_MISC);
        is_system = (opc == OPC_SYSTEM);

        known = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                is_store | is_op_imm | is_op | is_misc | is_system;

        illegal = (instr[1:0] != 2'b11) | ~known |
                  (is_op & ~((f7 == 7'h00) | (f7 == 7'h20) | (f7 == 7'h01))) |
                  (is_load & ((f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111))) |
                  (is_store & (f3 > 3'b010));

        // Bit 30 only selects SUB/SRA for OP and SRAI for the shift-immediates.
        f7b5 = is_op ? instr[30] :
               (is_op_imm & ((f3 == 3'b001) | (f3 == 3'b101))) ? instr[30] : 1'b0;

        if (is_store)
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (is_branch)
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (is_lui | is_auipc)
            imm = {instr[31:12], 12'b0};
        else if (is_jal)
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        else if (is_op)
            imm = 32'b0;
        else
            imm = {{20{instr[31]}}, instr[31:20]};

        u       = '0;
        u.pc    = pc;
        u.instr = instr;
        if (illegal) begin
            u.illegal = 1'b1;
        end else begin
            u.alu_opcode = {is_branch, f7b5, (is_load | is_store) ? 3'b000 : f3};
            u.alu_m_inst = is_op & (f7 == 7'h01);
            u.load_store = {is_load, is_store};
            u.rd_inst    = is_lui | is_auipc | is_jal | is_jalr | is_load | is_op_imm | is_op;
            u.cont_tra   = {is_jalr, is_jal, is_branch};
            u.imm        = imm;
        end
        return u;
    endfunction

    uop_t             mem [DEPTH];
    uop_t             lane_uop [FETCH_W];
    logic [PTR_W-1:0] lane_slot [FETCH_W];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, off;
    logic [CNT_W-1:0] push_cnt;
    logic             push, pop;
    uop_t             head;

    // Valid lanes are packed into consecutive slots; each lane's slot is
    // offset by the number of valid lanes below it.
    always_comb begin
        off      = '0;
        push_cnt = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            lane_uop[i]  = decode_lane(in_instr[32*i +: 32], in_pc[XLEN*i +: XLEN]);
            lane_slot[i] = wr_ptr + off;
            if (in_valid[i]) off = off + PTR_W'(1);
            push_cnt = push_cnt + CNT_W'(in_valid[i]);
        end
    end

    // Readiness looks only at the registered count, so a same-cycle pop
    // never lends space to the incoming group.
    assign in_ready  = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W);
    assign out_valid = (count != '0);
    assign push      = (|in_valid) & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (push ? push_cnt : '0) - (pop ? CNT_W'(1) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (in_valid[i]) mem[lane_slot[i]] <= lane_uop[i];
            end
        end
    end

    // Payload is forced to zero while empty so stale storage never shows.
    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_pc         = head.pc;
    assign out_instr      = head.instr;
    assign out_alu_opcode = head.alu_opcode;
    assign out_alu_m_inst = head.alu_m_inst;
    assign out_load_store = head.load_store;
    assign out_rd_inst    = head.rd_inst;
    assign out_cont_tra   = head.cont_tra;
    assign out_imm        = head.imm;
    assign out_illegal    = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue
// Directed vectors plus randomized traffic for decode_queue (XLEN=32,
// FETCH_W=2, DEPTH=8), compared against a queue-based reference model that
// decodes each op from the instruction encoding rules when it reaches the head.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_instr;
    logic [63:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_alu_opcode;
    logic        out_alu_m_inst;
    logic [1:0]  out_load_store;
    logic        out_rd_inst;
    logic [2:0]  out_cont_tra;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic [3:0]  count;

    decode_queue #(.XLEN(32), .FETCH_W(2), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_alu_opcode(out_alu_opcode),
        .out_alu_m_inst(out_alu_m_inst), .out_load_store(out_load_store),
        .out_rd_inst(out_rd_inst), .out_cont_tra(out_cont_tra), .out_imm(out_imm),
        .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct packed {
        logic [4:0]  alu;
        logic        m;
        logic [1:0]  ls;
        logic        rd;
        logic [2:0]  ct;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] x);
        exp_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] imm_i;
        f3    = x[14:12];
        f7    = x[31:25];
        imm_i = {{20{x[31]}}, x[31:20]};
        e     = '0;
        case (x[6:0])
            7'h37, 7'h17: begin e.rd = 1; e.alu = {2'b00, f3}; e.imm = {x[31:12], 12'h000}; end
            7'h6F: begin
                e.rd = 1; e.ct = 3'b010; e.alu = {2'b00, f3};
                e.imm = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            end
            7'h67: begin e.rd = 1; e.ct = 3'b100; e.alu = {2'b00, f3}; e.imm = imm_i; end
            7'h63: begin
                e.ct = 3'b001; e.alu = {2'b10, f3};
                e.imm = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            end
            7'h03: begin
                e.ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
                e.ls = 2'b10; e.rd = 1; e.imm = imm_i;
            end
            7'h23: begin
                e.ill = (f3 > 2); e.ls = 2'b01;
                e.imm = {{20{x[31]}}, x[31:25], x[11:7]};
            end
            7'h13: begin
                e.rd = 1; e.imm = imm_i;
                e.alu = {1'b0, ((f3 == 1) || (f3 == 5)) ? x[30] : 1'b0, f3};
            end
            7'h33: begin
                e.ill = !((f7 == 7'h00) || (f7 == 7'h20) || (f7 == 7'h01));
                e.rd = 1; e.m = (f7 == 7'h01); e.alu = {1'b0, x[30], f3};
            end
            7'h0F, 7'h73: begin e.alu = {2'b00, f3}; e.imm = imm_i; end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e     = '0;
            e.ill = 1;
        end
        return e;
    endfunction

    task automatic check_state();
        exp_t e;
        int   sz;
        sz = mq.size();
        check_val("count", 64'(count), 64'(sz));
        check_val("out_valid", 64'(out_valid), 64'(sz != 0));
        check_val("in_ready", 64'(in_ready), 64'((8 - sz) >= 2));
        if (sz != 0) begin
            e = ref_decode(mq[0].instr);
            check_val("out_pc", 64'(out_pc), 64'(mq[0].pc));
            check_val("out_instr", 64'(out_instr), 64'(mq[0].instr));
            check_val("alu_opcode", 64'(out_alu_opcode), 64'(e.alu));
            check_val("m_inst", 64'(out_alu_m_inst), 64'(e.m));
            check_val("load_store", 64'(out_load_store), 64'(e.ls));
            check_val("rd_inst", 64'(out_rd_inst), 64'(e.rd));
            check_val("cont_tra", 64'(out_cont_tra), 64'(e.ct));
            check_val("imm", 64'(out_imm), 64'(e.imm));
            check_val("illegal", 64'(out_illegal), 64'(e.ill));
        end
    endtask

    // One clock: drive inputs, advance the model by the queue rules, compare.
    task automatic do_cycle(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                            input logic [31:0] i1, input logic [31:0] p1,
                            input logic fl, input logic ordy);
        bit   exp_pop, exp_push;
        ent_t en;
        in_valid  = v;
        in_instr  = {i1, i0};
        in_pc     = {p1, p0};
        flush     = fl;
        out_ready = ordy;
        exp_pop   = (mq.size() != 0) && ordy;
        exp_push  = (v != 0) && ((8 - mq.size()) >= 2);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (exp_pop) void'(mq.pop_front());
            if (exp_push) begin
                if (v[0]) begin en.pc = p0; en.instr = i0; mq.push_back(en); end
                if (v[1]) begin en.pc = p1; en.instr = i1; mq.push_back(en); end
            end
        end
        #1;
        check_state();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                   7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] r;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 12);
        if (k < 11) r[6:0] = opcs[k];
        if (r[6:0] == 7'h33) begin
            case ($urandom_range(0, 4))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                3: r[31:25] = 7'h40;
                default: ;
            endcase
        end
        return r;
    endfunction

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] MUL  = 32'h02208033;
    localparam logic [31:0] BEQ  = 32'hFE000EE3;
    localparam logic [31:0] OP40 = 32'h80000033;
    localparam logic [31:0] NOPI = 32'h00000013;

    initial begin
        logic [1:0]  v;
        logic [31:0] i0, i1, pc;
        logic        fl, ordy, hold;

        rst_n = 1'b0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        #12;
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_pc", 64'(out_pc), 64'd0);
        check_val("rst_out_imm", 64'(out_imm), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADDI in lane 0 only
        do_cycle(2'b01, ADDI, 32'h100, NOPI, 32'h104, 0, 0);
        check_val("addi_valid", 64'(out_valid), 64'd1);
        check_val("addi_alu", 64'(out_alu_opcode), 64'd0);
        check_val("addi_imm", 64'(out_imm), 64'd5);
        check_val("addi_rd", 64'(out_rd_inst), 64'd1);
        check_val("addi_count", 64'(count), 64'd1);
        do_cycle(2'b00, 0, 0, 0, 0, 1, 0);

        // MUL in lane 1 only, compacted into a single entry
        do_cycle(2'b10, NOPI, 32'h200, MUL, 32'h204, 0, 0);
        check_val("mul_count", 64'(count), 64'd1);
        check_val("mul_pc", 64'(out_pc), 64'h204);
        check_val("mul_m", 64'(out_alu_m_inst), 64'd1);
        check_val("mul_alu", 64'(out_alu_opcode), 64'd0);
        check_val("mul_rd", 64'(out_rd_inst), 64'd1);
        do_cycle(2'b00, 0, 0, 0, 0, 1, 0);

        // BEQ -4
        do_cycle(2'b01, BEQ, 32'h300, NOPI, 32'h304, 0, 0);
        check_val("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
        check_val("beq_alu", 64'(out_alu_opcode), 64'h10);
        check_val("beq_ct", 64'(out_cont_tra), 64'b001);
        check_val("beq_rd", 64'(out_rd_inst), 64'd0);
        do_cycle(2'b00, 0, 0, 0, 0, 1, 0);

        // illegal encodings: all-zero and OP with funct7=0x40
        do_cycle(2'b11, 32'h0, 32'h400, OP40, 32'h404, 0, 0);
        check_val("ill0_flag", 64'(out_illegal), 64'd1);
        check_val("ill0_ctrl", 64'({out_alu_opcode, out_alu_m_inst, out_load_store,
                                     out_rd_inst, out_cont_tra}), 64'd0);
        do_cycle(2'b00, 0, 0, 0, 0, 0, 1);
        check_val("ill40_flag", 64'(out_illegal), 64'd1);
        check_val("ill40_ctrl", 64'({out_alu_opcode, out_alu_m_inst, out_load_store,
                                      out_rd_inst, out_cont_tra}), 64'd0);
        do_cycle(2'b00, 0, 0, 0, 0, 1, 0);

        // fill to full with dispatch stalled
        pc = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            do_cycle(2'b11, rand_instr(), pc, rand_instr(), pc + 4, 0, 0);
            pc += 8;
        end
        check_val("full_count", 64'(count), 64'd8);
        check_val("full_in_ready", 64'(in_ready), 64'd0);
        do_cycle(2'b00, 0, 0, 0, 0, 0, 1);
        check_val("cnt7_in_ready", 64'(in_ready), 64'd0);
        // drain while refilling so pointers wrap
        for (int k = 0; k < 12; k++) begin
            v = (k % 2 == 0) ? 2'b11 : 2'b00;
            do_cycle(v, rand_instr(), pc, rand_instr(), pc + 4, 0, 1);
            if (v != 0 && in_ready) pc += 8;
        end
        do_cycle(2'b00, 0, 0, 0, 0, 1, 0);

        // flush at count 5 with push and pop requested
        do_cycle(2'b11, rand_instr(), 32'h2000, rand_instr(), 32'h2004, 0, 0);
        do_cycle(2'b11, rand_instr(), 32'h2008, rand_instr(), 32'h200C, 0, 0);
        do_cycle(2'b01, rand_instr(), 32'h2010, rand_instr(), 32'h2014, 0, 0);
        check_val("pre_flush_count", 64'(count), 64'd5);
        do_cycle(2'b11, rand_instr(), 32'h2018, rand_instr(), 32'h201C, 1, 1);
        check_val("flush_count", 64'(count), 64'd0);
        check_val("flush_valid", 64'(out_valid), 64'd0);
        check_val("flush_in_ready", 64'(in_ready), 64'd1);

        // asynchronous reset mid-stream, no clock edge involved
        do_cycle(2'b11, rand_instr(), 32'h3000, rand_instr(), 32'h3004, 0, 0);
        do_cycle(2'b11, rand_instr(), 32'h3008, rand_instr(), 32'h300C, 0, 0);
        in_valid = 0;
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_count", 64'(count), 64'd0);
        check_val("arst_valid", 64'(out_valid), 64'd0);
        mq.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_state();

        // randomized traffic; fetch holds its lanes while refused
        hold = 0; v = 0; i0 = 0; i1 = 0; pc = 32'h8000;
        for (int k = 0; k < 600; k++) begin
            if (!hold) begin
                v  = 2'($urandom_range(0, 3));
                i0 = rand_instr();
                i1 = rand_instr();
                pc += 8;
            end
            fl   = ($urandom_range(0, 39) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            hold = (v != 0) && ((8 - mq.size()) < 2);
            do_cycle(v, i0, pc, i1, pc + 4, fl, ordy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
